mdu_hilo: RTL and testbench

- Execute-stage multiply/divide unit owning the architectural HI and LO registers.
- Consumes the decoder's isHILO/HILOtype pair together with the forwarded rs/rt operands.
- Runs mult/multu for a fixed multi-cycle latency and div/divu for a longer one.
- Exposes busy to the hazard unit and supplies HI/LO for mfhi/mflo writeback.

---
 rtl/mdu_hilo_pkg.sv | 23 ++
 rtl/mdu_hilo_if.sv | 25 ++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu_hilo.sv | 95 +++++++++
 tb/tb_mdu_hilo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the mdu_hilo multiply/divide unit: operation codes,
// FSM state values and default latencies.
package mdu_hilo_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } hilo_op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_hilo_if.sv
// Decoder/hazard-unit side bundle of the mdu_hilo unit.
// With MDU_ABORT_EN defined the bundle also carries the abort flush.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  HILOtype;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HILO_out;
`ifdef MDU_ABORT_EN
  logic        abort;

  modport master (output start, HILOtype, A, B, abort,
                  input  busy, HI, LO, HILO_out);
  modport slave  (input  start, HILOtype, A, B, abort,
                  output busy, HI, LO, HILO_out);
`else
  modport master (output start, HILOtype, A, B,
                  input  busy, HI, LO, HILO_out);
  modport slave  (input  start, HILOtype, A, B,
                  output busy, HI, LO, HILO_out);
`endif
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO result for the latched operation and operands.
// o_keep flags a divide by zero, where HI and LO must stay unchanged.
module mdu_arith
  import mdu_hilo_pkg::*;
(
  input  hilo_op_e    i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_keep
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_sdiv;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
  assign w_sdiv = (i_op == OP_DIV);
  assign w_dvd  = (w_sdiv && i_a[31]) ? -i_a : i_a;
  assign w_dvs  = (i_b == 32'd0) ? 32'd1 : ((w_sdiv && i_b[31]) ? -i_b : i_b);
  assign w_q    = w_dvd / w_dvs;
  assign w_r    = w_dvd % w_dvs;
  assign w_quot = (w_sdiv && (i_a[31] ^ i_b[31])) ? -w_q : w_q;
  assign w_rem  = (w_sdiv && i_a[31]) ? -w_r : w_r;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_result = 64'd0;
    o_keep   = 1'b0;
    case (i_op)
      OP_MULT:  o_result = w_smul;
      OP_MULTU: o_result = w_umul;
      OP_DIV, OP_DIVU: begin
        o_result = {w_rem, w_quot};
        o_keep   = (i_b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit owning HI and LO.
// Define MDU_ABORT_EN to add an abort flush input on the interface.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_hilo_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  hilo_op_e      r_op;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  hilo_op_e      w_op;
  logic          w_abort;
  logic [63:0]   w_result;
  logic          w_keep;

  assign w_op = hilo_op_e'(bus.HILOtype);

`ifdef MDU_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  mdu_arith u_arith (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result),
    .o_keep   (w_keep)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == ST_IDLE) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (bus.start && !w_abort) begin
        case (w_op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_op    <= w_op;
            r_cnt   <= (w_op == OP_MULT || w_op == OP_MULTU) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_state <= ST_BUSY;
          end
          OP_MTHI: r_hi <= bus.A;
          OP_MTLO: r_lo <= bus.A;
          default: ;
        endcase
      end
    end else begin
      // Any start seen while busy is dropped; the hazard unit never issues one.
      if (w_abort) begin
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else if (r_cnt == CW'(1)) begin
        if (!w_keep) begin
          r_hi <= w_result[63:32];
          r_lo <= w_result[31:0];
        end
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.busy     = (r_state == ST_BUSY);
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  assign bus.HILO_out = (w_op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: completions are queued at issue and checked
// by a monitor when busy falls. Abort cases run only with MDU_ABORT_EN.
module tb_mdu_hilo;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] T_NONE = 4'd0, T_MULT = 4'd1, T_MULTU = 4'd2,
                         T_DIV  = 4'd3, T_DIVU = 4'd4, T_MFHI  = 4'd5,
                         T_MFLO = 4'd6, T_MTHI = 4'd7, T_MTLO  = 4'd8;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.HILOtype = t;
    bus.A        = a;
    bus.B        = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.HILOtype = T_NONE;
  endtask

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input int cycles);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.cycles = cycles;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bus.HILOtype = T_MFHI;
    #1 check({name, "_mfhi"}, bus.HILO_out, hi);
    bus.HILOtype = T_MFLO;
    #1 check({name, "_mflo"}, bus.HILO_out, lo);
    bus.HILOtype = T_NONE;
  endtask

  // Monitor: counts busy cycles and checks HI/LO whenever busy falls.
  initial begin
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (bus.busy) run++;
        else if (prev) begin
          if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check({e.name, "_cycles"}, run, e.cycles);
            check({e.name, "_hi"}, bus.HI, e.hi);
            check({e.name, "_lo"}, bus.LO, e.lo);
          end
          run = 0;
        end
        prev = bus.busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.HILOtype = T_NONE;
    bus.A        = '0;
    bus.B        = '0;
`ifdef MDU_ABORT_EN
    bus.abort    = 1'b0;
`endif
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.HI, 0);
    check("rst_lo", bus.LO, 0);
    check("rst_hilo_out", bus.HILO_out, 0);
    @(negedge clk);
    reset = 1'b1;

    expect_op("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, MC);
    issue(T_MULT, 32'hFFFFFFFF, 32'd2);
    wait_idle("mult");
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    expect_op("multu", 32'h00000001, 32'hFFFFFFFE, MC);
    issue(T_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu");

    expect_op("mult_minmax", 32'hC0000000, 32'h80000000, MC);
    issue(T_MULT, 32'h7FFFFFFF, 32'h80000000);
    wait_idle("mult_minmax");

    expect_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    issue(T_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg");

    expect_op("div_negdiv", 32'h00000001, 32'hFFFFFFFD, DC);
    issue(T_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_negdiv");

    expect_op("divu", 32'd1, 32'd3, DC);
    issue(T_DIVU, 32'd7, 32'd2);
    wait_idle("divu");
    read_hilo("divu", 32'd1, 32'd3);

    expect_op("div_ovf", 32'd0, 32'h80000000, DC);
    issue(T_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    issue(T_MTHI, 32'h12345678, 32'd0);
    issue(T_MTLO, 32'd0, 32'd0);
    read_hilo("mthi_mtlo", 32'h12345678, 32'd0);
    expect_op("divu_zero", 32'h12345678, 32'd0, DC);
    issue(T_DIVU, 32'd5, 32'd0);
    wait_idle("divu_zero");

    // Reset pulled low on busy cycle 3 of a multiply.
    issue(T_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_hi", bus.HI, 0);
    check("rstmid_lo", bus.LO, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rstmid_late_busy", bus.busy, 0);
    check("rstmid_late_hi", bus.HI, 0);
    check("rstmid_late_lo", bus.LO, 0);

    // mtlo while busy must be dropped; the multiply result lands.
    expect_op("mult_mtlo_busy", 32'd0, 32'd42, MC);
    issue(T_MULT, 32'd6, 32'd7);
    bus.start = 1'b1; bus.HILOtype = T_MTLO; bus.A = 32'h0000DEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.HILOtype = T_NONE;
    wait_idle("mult_mtlo_busy");

    // mthi/mtlo/mult while a divide-by-zero is busy must leave HI/LO alone.
    expect_op("div0_start_busy", 32'd0, 32'd42, DC);
    issue(T_DIV, 32'd9, 32'd0);
    issue(T_MTHI, 32'hBEEF0001, 32'd0);
    issue(T_MTLO, 32'hBEEF0002, 32'd0);
    issue(T_MULT, 32'd100, 32'd100);
    wait_idle("div0_start_busy");
    repeat (MC + 2) @(negedge clk);
    check("div0_after_busy", bus.busy, 0);
    check("div0_after_lo", bus.LO, 32'd42);

`ifdef MDU_ABORT_EN
    issue(T_MTHI, 32'hAAAA0000, 32'd0);
    issue(T_MTLO, 32'h0000BBBB, 32'd0);
    expect_op("abort", 32'hAAAA0000, 32'h0000BBBB, 2);
    issue(T_MULT, 32'd2, 32'd3);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_idle("abort");
    bus.start = 1'b1; bus.HILOtype = T_MTHI; bus.A = 32'h11111111; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.HILOtype = T_NONE; bus.abort = 1'b0;
    @(negedge clk);
    check("abort_idle_hi", bus.HI, 32'hAAAA0000);
    check("abort_idle_busy", bus.busy, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
